// File: rtl/dsp_wb_master.sv
// Wishbone B3 classic single-transfer master for the DSP file sequencer.
// One launch per rising start edge; every cycle ends on err, ack or timeout so the requester never hangs.
module dsp_wb_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] address,
  input  logic          start,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic          bus_error,
  output logic [1:0]    err_code,
  output logic [15:0]   xfer_count,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  BUSY     = 1'b1;
  localparam logic [1:0]  ERR_BUS  = 2'b01;
  localparam logic [1:0]  ERR_TMO  = 2'b10;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [0:0]  state;
  logic        start_q;
  logic [15:0] timer;
  logic        launch;
  logic        end_err;
  logic        end_ack;
  logic        end_tmo;
  logic        xfer_end;

  // Termination causes are mutually exclusive: err beats ack, ack beats timeout.
  assign launch   = start & ~start_q & (state == IDLE);
  assign end_err  = (state == BUSY) & wb_err_i;
  assign end_ack  = (state == BUSY) & ~wb_err_i & wb_ack_i;
  assign end_tmo  = (state == BUSY) & ~wb_err_i & ~wb_ack_i & (timer == TMO_LAST);
  assign xfer_end = end_err | end_ack | end_tmo;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      timer    <= 16'd0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      active   <= 1'b0;
    end else if (launch) begin
      state    <= BUSY;
      timer    <= 16'd0;
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      active   <= 1'b1;
    end else if (xfer_end) begin
      state    <= IDLE;
      timer    <= 16'd0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      active   <= 1'b0;
    end else if (state == BUSY) begin
      timer <= timer + 16'd1;
    end
  end

  // Request fields are captured only at launch so the bus stays stable while BUSY.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= 4'h0;
      wb_we_o  <= 1'b0;
    end else if (launch) begin
      wb_adr_o <= address;
      wb_dat_o <= data_wr;
      wb_sel_o <= selection;
      wb_we_o  <= write;
    end else if (xfer_end) begin
      wb_we_o  <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      data_rd    <= '0;
      bus_error  <= 1'b0;
      err_code   <= 2'b00;
      xfer_count <= 16'd0;
    end else begin
      bus_error <= end_err | end_tmo;
      if (end_ack && !wb_we_o) begin
        data_rd <= wb_dat_i;
      end
      if (end_err) begin
        err_code <= ERR_BUS;
      end else if (end_tmo) begin
        err_code <= ERR_TMO;
      end
      if (xfer_end) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule
